// File: rtl/reg8_serial_tx.sv
// Framed parallel-in serial-out transmitter: start, data, optional parity, stop.
// Define TX_PARITY_EN to insert an even parity bit between data and stop.
module reg8_serial_tx #(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic [WIDTH-1:0] Reg_In,
    output logic             ready,
    output logic             busy,
    output logic             ser_out,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t          state_q, state_nx;
    logic [WIDTH-1:0] data_q, data_nx;
    logic [CW-1:0]    cnt_q, cnt_nx;
    logic             ser_q, ser_nx;
    logic             done_q, done_nx;
    logic [WIDTH-1:0] ordered;
    logic [WIDTH-1:0] ord_sh;
    logic [CW-1:0]    cnt_inc;

    // Data reordered so transmit order always walks upward from bit 0
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_ord
            if (LSB_FIRST) begin : g_lsb
                assign ordered[g] = data_q[g];
            end else begin : g_msb
                assign ordered[g] = data_q[WIDTH-1-g];
            end
        end
    endgenerate

    assign cnt_inc = cnt_q + CW'(1);
    assign ord_sh  = ordered >> cnt_inc;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            ser_q   <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            data_q  <= data_nx;
            cnt_q   <= cnt_nx;
            ser_q   <= ser_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        data_nx  = data_q;
        cnt_nx   = cnt_q;
        ser_nx   = ser_q;
        done_nx  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ser_nx = IDLE_LEVEL;
                if (load) begin
                    data_nx  = Reg_In;
                    cnt_nx   = '0;
                    state_nx = S_START;
                    ser_nx   = ~IDLE_LEVEL;
                end
            end
            S_START: begin
                if (EN) begin
                    state_nx = S_DATA;
                    ser_nx   = ordered[0];
                end
            end
            S_DATA: begin
                if (EN) begin
                    // Counter ends at WIDTH, which CW bits always hold
                    cnt_nx = cnt_inc;
                    if (cnt_q == LAST) begin
`ifdef TX_PARITY_EN
                        state_nx = S_PARITY;
                        ser_nx   = ^data_q;
`else
                        state_nx = S_STOP;
                        ser_nx   = IDLE_LEVEL;
`endif
                    end else begin
                        ser_nx = ord_sh[0];
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (EN) begin
                    state_nx = S_STOP;
                    ser_nx   = IDLE_LEVEL;
                end
            end
`endif
            S_STOP: begin
                ser_nx = IDLE_LEVEL;
                if (EN) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                ser_nx   = IDLE_LEVEL;
            end
        endcase
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = ~ready;
    assign ser_out = ser_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reg8_serial_tx.sv
// Scoreboard bench for reg8_serial_tx: stimulus queues per-clock expectations,
// a monitor pops and compares them one clock later.
module tb_reg8_serial_tx;

    logic       clk = 1'b0;
    logic       res;
    logic       EN;
    logic       load_a, load_b;
    logic [7:0] Reg_In;
    logic       ready_a, busy_a, ser_a, done_a;
    logic       ready_b, busy_b, ser_b, done_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit   sel;
        logic ser;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    reg8_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_a (
        .clk(clk), .res(res), .EN(EN), .load(load_a), .Reg_In(Reg_In),
        .ready(ready_a), .busy(busy_a), .ser_out(ser_a), .done(done_a)
    );

    reg8_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
        .clk(clk), .res(res), .EN(EN), .load(load_b), .Reg_In(Reg_In),
        .ready(ready_b), .busy(busy_b), .ser_out(ser_b), .done(done_b)
    );

`ifdef TX_PARITY_EN
    localparam string P_A5 = "01010010101";
    localparam string P_77 = "01110111001";
    localparam string P_5A = "00101101001";
    localparam string P_3C = "00011110001";
    localparam string P_01 = "01000000011";
    localparam string P_80 = "01000000011";
`else
    localparam string P_A5 = "0101001011";
    localparam string P_77 = "0111011101";
    localparam string P_5A = "0010110101";
    localparam string P_3C = "0001111001";
    localparam string P_01 = "0100000001";
    localparam string P_80 = "0100000001";
`endif

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic ld, input logic en,
                         input logic [7:0] d, input logic es, input logic eb,
                         input logic er, input logic ed);
        exp_t e;
        load_a = ld & ~sel;
        load_b = ld & sel;
        EN     = en;
        Reg_In = d;
        e.sel = sel; e.ser = es; e.busy = eb; e.ready = er; e.done = ed;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // One frame; EN pulses every p clocks after the accept edge.
    task automatic tx(input bit sel, input logic [7:0] d, input int p,
                      input string pat, input bit hold, input bit cont,
                      input logic [7:0] nxt);
        int n;
        n = pat.len();
        if (!cont)
            drive(sel, 1'b1, p == 1, d, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= n * p; k++) begin
            logic ld;
            ld = hold | (k == 2);
            if (k == n * p)
                drive(sel, ld, (k % p) == 0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
            else
                drive(sel, ld, (k % p) == 0, 8'h3C,
                      pat[k / p] == "1", 1'b1, 1'b0, 1'b0);
        end
        if (hold)
            drive(sel, 1'b1, p == 1, nxt, 1'b0, 1'b1, 1'b0, 1'b0);
        else
            drive(sel, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel) begin
                    chk("b_ser", ser_b, e.ser);
                    chk("b_busy", busy_b, e.busy);
                    chk("b_ready", ready_b, e.ready);
                    chk("b_done", done_b, e.done);
                end else begin
                    chk("a_ser", ser_a, e.ser);
                    chk("a_busy", busy_a, e.busy);
                    chk("a_ready", ready_a, e.ready);
                    chk("a_done", done_a, e.done);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        res    = 1'b1;
        EN     = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        Reg_In = 8'h00;
        #3;
        chk("rst_ser", ser_a, 1'b1);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_b_ser", ser_b, 1'b1);
        @(posedge clk);
        #2;
        res = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        drive(0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        res = 1'b1;
        #2;
        chk("abort_ser", ser_a, 1'b1);
        chk("abort_ready", ready_a, 1'b1);
        chk("abort_busy", busy_a, 1'b0);
        #2;
        res = 1'b0;
        drive(0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        tx(0, 8'hA5, 1, P_A5, 1'b0, 1'b0, 8'h00);
        tx(0, 8'h77, 4, P_77, 1'b0, 1'b0, 8'h00);
        tx(0, 8'h5A, 1, P_5A, 1'b1, 1'b0, 8'h3C);
        tx(0, 8'h3C, 1, P_3C, 1'b0, 1'b1, 8'h00);
        tx(0, 8'h01, 1, P_01, 1'b0, 1'b0, 8'h00);
        tx(1, 8'h80, 1, P_80, 1'b0, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
